// File: rtl/fb_pkg.sv
// Shared geometry, widths and state encoding for the text framebuffer port arbiter.
package fb_pkg;
  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;
  localparam int AW    = 12;
  localparam int DW    = 8;
  localparam logic [DW-1:0] CLR_CHAR = 8'h20;

  typedef enum logic {IDLE, CLEAR} fb_state_e;
endpackage

// File: rtl/fb_clear_seq.sv
// Clear address sequencer: walks 0..NCELLS-1 one step per granted cycle and flags the last cell.
module fb_clear_seq #(
  parameter int ADDR_W = 12,
  parameter int NCELLS = 2400
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NCELLS - 1);

  logic [ADDR_W-1:0] addr_q, addr_d;

  // Wrap to 0 after the last cell so the counter never leaves the screen range.
  always_comb begin
    addr_d = addr_q;
    if (start)     addr_d = '0;
    else if (step) addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) addr_q <= '0;
    else      addr_q <= addr_d;
  end

  assign addr = addr_q;
  assign last = (addr_q == LAST_ADDR);
endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port RAM arbiter: display fetch > full-screen clear > host write, with a
// fixed two-cycle registered fetch pipeline.
module fb_port_arbiter #(
  parameter int COLS = fb_pkg::COLS,
  parameter int ROWS = fb_pkg::ROWS,
  parameter int AW   = fb_pkg::AW,
  parameter int DW   = fb_pkg::DW,
  parameter logic [DW-1:0] CLR_CHAR = fb_pkg::CLR_CHAR
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic [DW-1:0] disp_data,
  output logic          disp_valid,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          clr_start,
  output logic          clr_busy,
  output logic [7:0]    wr_drop_cnt,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);
  localparam int            CELLS   = COLS * ROWS;
  localparam logic [AW-1:0] CELLS_A = AW'(CELLS);

  fb_pkg::fb_state_e state_q;
  logic              clr_busy_q;
  logic [AW-1:0]     clr_addr;
  logic              clr_last, clr_gnt, clr_load;
  logic              disp_inrng, wr_inrng, wr_acc;

  assign disp_inrng = (disp_addr < CELLS_A);
  assign wr_inrng   = (wr_addr < CELLS_A);
  assign clr_gnt    = (state_q == fb_pkg::CLEAR) && !disp_req;
  assign clr_load   = (state_q == fb_pkg::IDLE) && clr_start;
  assign wr_ready   = (state_q == fb_pkg::IDLE) && !disp_req && !clr_start;
  assign wr_acc     = wr_valid && wr_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= fb_pkg::IDLE;
      clr_busy_q <= 1'b0;
    end else begin
      case (state_q)
        fb_pkg::IDLE: if (clr_start) begin
          state_q    <= fb_pkg::CLEAR;
          clr_busy_q <= 1'b1;
        end
        fb_pkg::CLEAR: if (clr_gnt && clr_last) begin
          state_q    <= fb_pkg::IDLE;
          clr_busy_q <= 1'b0;
        end
        default: begin
          state_q    <= fb_pkg::IDLE;
          clr_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign clr_busy = clr_busy_q;

  fb_clear_seq #(.ADDR_W(AW), .NCELLS(CELLS)) u_clr_seq (
    .clk   (clk),
    .rst   (rst),
    .start (clr_load),
    .step  (clr_gnt),
    .addr  (clr_addr),
    .last  (clr_last)
  );

  // An out-of-range fetch still owns the port that cycle; it just leaves ram_en low.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = disp_addr;
    ram_wdata = '0;
    if (disp_req) begin
      ram_en   = disp_inrng;
      ram_addr = disp_addr;
    end else if (clr_gnt) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = clr_addr;
      ram_wdata = CLR_CHAR;
    end else if (wr_acc) begin
      ram_en    = wr_inrng;
      ram_we    = wr_inrng;
      ram_addr  = wr_addr;
      ram_wdata = wr_data;
    end
  end

  logic [2:1]    vld_pipe_q, vld_pipe_d;
  logic          oob_q, oob_d;
  logic [DW-1:0] disp_data_q, disp_data_d;
  logic [7:0]    drop_q, drop_d;

  always_comb begin
    vld_pipe_d[1] = disp_req;
    vld_pipe_d[2] = vld_pipe_q[1];
    oob_d         = !disp_inrng;
    disp_data_d   = disp_data_q;
    if (vld_pipe_q[1]) disp_data_d = oob_q ? '0 : ram_rdata;
    drop_d = drop_q;
    if (wr_acc && !wr_inrng && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe_q  <= '0;
      oob_q       <= 1'b0;
      disp_data_q <= '0;
      drop_q      <= '0;
    end else begin
      vld_pipe_q  <= vld_pipe_d;
      oob_q       <= oob_d;
      disp_data_q <= disp_data_d;
      drop_q      <= drop_d;
    end
  end

  assign disp_valid  = vld_pipe_q[2];
  assign disp_data   = disp_data_q;
  assign wr_drop_cnt = drop_q;
endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench with a behavioural sync RAM and a fetch scoreboard checked on disp_valid.
module tb_fb_port_arbiter;
  localparam int AW = 12;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          disp_req = 1'b0;
  logic [AW-1:0] disp_addr = '0;
  logic [DW-1:0] disp_data;
  logic          disp_valid;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          clr_start = 1'b0;
  logic          clr_busy;
  logic [7:0]    wr_drop_cnt;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;

  fb_port_arbiter dut (
    .clk(clk), .rst(rst),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_start(clr_start), .clr_busy(clr_busy), .wr_drop_cnt(wr_drop_cnt),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem     [4096];
  logic [DW-1:0] exp_mem [4096];
  always @(posedge clk) if (ram_en) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q [$];
  int            cyc_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic fetch_push(input int a);
    disp_req  = 1'b1;
    disp_addr = AW'(a);
    exp_q.push_back((a >= 2400) ? 8'h00 : exp_mem[a]);
    cyc_q.push_back(cyc_cnt);
  endtask

  logic [DW-1:0] mon_d;
  int            mon_c;
  always @(negedge clk) if (rst && disp_valid) begin
    if (exp_q.size() == 0) chk("unexpected_disp_valid", 1, 0);
    else begin
      mon_d = exp_q.pop_front();
      mon_c = cyc_q.pop_front();
      chk("disp_data", {24'd0, disp_data}, {24'd0, mon_d});
      chk("disp_latency", cyc_cnt, mon_c + 2);
    end
  end

  int  exp_clr, bad;
  bit  done;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i]     = 8'(i) ^ 8'h5A;
      exp_mem[i] = 8'(i) ^ 8'h5A;
    end

    // reset state
    #3;
    chk("rst_clr_busy", clr_busy, 0);
    chk("rst_disp_valid", disp_valid, 0);
    chk("rst_disp_data", disp_data, 0);
    chk("rst_drop_cnt", wr_drop_cnt, 0);
    chk("rst_wr_ready", wr_ready, 1);
    tick(); tick();
    rst = 1'b1;
    tick();

    // host write to 5, then fetch it back
    wr_valid = 1'b1; wr_addr = 12'd5; wr_data = 8'h41;
    @(negedge clk);
    chk("wr5_ready", wr_ready, 1);
    chk("wr5_ram_en", ram_en, 1);
    chk("wr5_ram_we", ram_we, 1);
    chk("wr5_ram_addr", ram_addr, 5);
    chk("wr5_ram_wdata", ram_wdata, 8'h41);
    exp_mem[5] = 8'h41;
    tick(); wr_valid = 1'b0; fetch_push(5);
    tick(); disp_req = 1'b0;
    tick(); tick(); tick();

    // host write stalled by 3 display fetches
    wr_valid = 1'b1; wr_addr = 12'd10; wr_data = 8'h55;
    for (int i = 0; i < 3; i++) begin
      fetch_push(5);
      @(negedge clk);
      chk("stall_wr_ready", wr_ready, 0);
      chk("stall_ram_we", ram_we, 0);
      tick();
    end
    disp_req = 1'b0;
    @(negedge clk);
    chk("unstall_wr_ready", wr_ready, 1);
    chk("unstall_ram_we", ram_we, 1);
    chk("unstall_ram_addr", ram_addr, 10);
    exp_mem[10] = 8'h55;
    tick(); wr_valid = 1'b0; fetch_push(10);
    tick(); fetch_push(5);
    tick(); fetch_push(2400);
    tick(); disp_req = 1'b0;
    tick(); tick(); tick();

    // clear racing a host write, with fetches interleaved and a second clr_start
    clr_start = 1'b1; wr_valid = 1'b1; wr_addr = 12'd20; wr_data = 8'hEE;
    @(negedge clk);
    chk("clr_start_wr_ready", wr_ready, 0);
    chk("clr_start_ram_en", ram_en, 0);
    exp_clr = 0; bad = 0; done = 1'b0;
    for (int c = 0; c < 6000 && !done; c++) begin
      tick();
      clr_start = (c == 500);
      if (c % 2 == 0) fetch_push(3000); else disp_req = 1'b0;
      @(negedge clk);
      if (wr_ready || (disp_req && ram_en) || !clr_busy) bad++;
      if (ram_en && ram_we) begin
        chk("clr_addr", ram_addr, exp_clr);
        chk("clr_data", ram_wdata, 8'h20);
        if (exp_clr == 2399) done = 1'b1;
        exp_clr++;
      end
    end
    chk("clr_write_count", exp_clr, 2400);
    chk("clr_bad_cycles", bad, 0);
    tick(); disp_req = 1'b0; clr_start = 1'b0; wr_valid = 1'b0;
    @(negedge clk);
    chk("clr_busy_drop", clr_busy, 0);
    for (int i = 0; i < 2400; i++) exp_mem[i] = 8'h20;
    tick(); fetch_push(5);
    tick(); fetch_push(2399);
    tick(); disp_req = 1'b0;
    tick(); tick(); tick();

    // out-of-range host writes saturate the drop counter
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      wr_valid = 1'b1; wr_addr = 12'd2400; wr_data = 8'h77;
      @(negedge clk);
      if (ram_en || !wr_ready) bad++;
      tick();
    end
    wr_valid = 1'b0;
    chk("drop_no_ram", bad, 0);
    @(negedge clk);
    chk("drop_cnt_sat", wr_drop_cnt, 255);
    tick(); fetch_push(2400);
    tick(); disp_req = 1'b0;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) tick();
    chk("sb_drain_pre_rst", exp_q.size(), 0);

    // reset mid-clear with a fetch in flight
    clr_start = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge clk);
      if (ram_we && ram_addr == 12'd1000) done = 1'b1;
      tick();
      clr_start = 1'b0;
    end
    chk("rst_reached_1000", done, 1);
    disp_req = 1'b1; disp_addr = 12'd5;
    tick(); disp_req = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("rst_mid_clr_busy", clr_busy, 0);
    chk("rst_mid_disp_valid", disp_valid, 0);
    chk("rst_mid_disp_data", disp_data, 0);
    tick(); tick();
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (disp_valid) bad++;
      tick();
    end
    chk("post_rst_no_valid", bad, 0);
    wr_valid = 1'b1; wr_addr = 12'd30; wr_data = 8'h99;
    @(negedge clk);
    chk("post_rst_wr_ready", wr_ready, 1);
    chk("post_rst_ram_we", ram_we, 1);
    chk("post_rst_ram_addr", ram_addr, 30);
    exp_mem[30] = 8'h99;
    tick(); wr_valid = 1'b0; fetch_push(30);
    tick(); fetch_push(999);
    tick(); disp_req = 1'b0;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) tick();
    chk("sb_drain_end", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
